// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-level arbiter sharing the GMII tx path between the ARP and UDP engines.
// Optional per-grant watchdog is built when ETH_TX_ARB_WATCHDOG_EN is defined.
module eth_tx_arbiter #(
  parameter bit ARP_PRIORITY     = 1'b1,
  parameter int IFG_CYCLES       = 12,
  parameter int MAX_FRAME_CYCLES = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arp_req,
  output logic       arp_gnt,
  input  logic       arp_done,
  input  logic       arp_gmii_tx_en,
  input  logic [7:0] arp_gmii_txd,
  input  logic       udp_req,
  output logic       udp_gnt,
  input  logic       udp_done,
  input  logic       udp_gmii_tx_en,
  input  logic [7:0] udp_gmii_txd,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       arb_err
);
  typedef enum logic [1:0] {IDLE, GNT_ARP, GNT_UDP, IFG} state_t;
  localparam logic [7:0] GAP_LAST = 8'(IFG_CYCLES - 1);
  state_t state, state_nxt;
  logic last_arp;
  logic [7:0] gap_cnt;
  logic granted, done, abort, pick_arp;
  assign granted = state == GNT_ARP || state == GNT_UDP;
  assign done = state == GNT_ARP ? arp_done : state == GNT_UDP && udp_done;
  // on a tie without priority, the source that did not own the last frame wins
  assign pick_arp = arp_req && (!udp_req || ARP_PRIORITY || !last_arp);
  assign arp_gnt = state == GNT_ARP;
  assign udp_gnt = state == GNT_UDP;
  assign busy = state != IDLE;
`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam logic [11:0] WD_LAST = 12'(MAX_FRAME_CYCLES - 1);
  logic [11:0] wd_cnt;
  assign abort = granted && !done && wd_cnt == WD_LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd_cnt  <= '0;
      arb_err <= 1'b0;
    end else begin
      wd_cnt  <= granted ? wd_cnt + 12'd1 : '0;
      arb_err <= abort;
    end
`else
  assign abort = 1'b0;
  assign arb_err = 1'b0 && MAX_FRAME_CYCLES > 0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = pick_arp ? GNT_ARP : udp_req ? GNT_UDP : IDLE;
      IFG:     state_nxt = gap_cnt == GAP_LAST ? IDLE : IFG;
      default: state_nxt = done || abort ? IFG : state;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_arp   <= 1'b0;
      gap_cnt    <= '0;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
    end else begin
      if (state == IDLE && state_nxt != IDLE) last_arp <= state_nxt == GNT_ARP;
      gap_cnt    <= state == IFG ? gap_cnt + 8'd1 : '0;
      gmii_tx_en <= state == GNT_ARP ? arp_gmii_tx_en : state == GNT_UDP && udp_gmii_tx_en;
      gmii_txd   <= state == GNT_ARP ? arp_gmii_txd : state == GNT_UDP ? udp_gmii_txd : 8'h00;
    end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: two arbiters (ARP priority and round-robin) driven by randomized requesters,
// checked every cycle against a timestamp-based model of the grant/gap rules.
module tb_eth_tx_arbiter;
  localparam int IFG = 12;
  localparam int MAX = 100;
`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req[2][2], tx_en[2][2], done[2][2];
  logic [7:0] txd[2][2];
  logic arp_gnt[2], udp_gnt[2], gmii_tx_en[2], busy[2], arb_err[2];
  logic [7:0] gmii_txd[2];
  int n_chk = 0, n_fail = 0;
  bit stop;
  int m_n[2], m_free[2], m_g[2], m_own[2], m_last[2];
  logic m_busy[2], m_err[2], m_en[2];
  logic [7:0] m_txd[2];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    eth_tx_arbiter #(.ARP_PRIORITY(i == 0), .IFG_CYCLES(IFG), .MAX_FRAME_CYCLES(MAX)) u_dut (
      .clk(clk), .rst(rst),
      .arp_req(req[i][0]), .arp_gnt(arp_gnt[i]), .arp_done(done[i][0]),
      .arp_gmii_tx_en(tx_en[i][0]), .arp_gmii_txd(txd[i][0]),
      .udp_req(req[i][1]), .udp_gnt(udp_gnt[i]), .udp_done(done[i][1]),
      .udp_gmii_tx_en(tx_en[i][1]), .udp_gmii_txd(txd[i][1]),
      .gmii_tx_en(gmii_tx_en[i]), .gmii_txd(gmii_txd[i]), .busy(busy[i]), .arb_err(arb_err[i])
    );
  end

  function automatic logic gnt_of(input int k, input int s);
    return s == 1 ? udp_gnt[k] : arp_gnt[k];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int k, input int s);
    tx_en[k][s] = 1'b0;
    txd[k][s] = 8'h00;
    done[k][s] = 1'b0;
  endtask

  task automatic noise(input int k, input int s);
    tx_en[k][s] = 1'($urandom);
    txd[k][s] = 8'($urandom);
    done[k][s] = $urandom_range(0, 7) == 0;
  endtask

  // Model: a grant happens at the first edge that is both past the gap and sees a request;
  // a frame ends on the owner's done (or the watchdog deadline), opening a gap of IFG cycles.
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_free[k] = 0; m_g[k] = 0; m_own[k] = 0; m_last[k] = 2;
      m_busy[k] = 1'b0; m_err[k] = 1'b0; m_en[k] = 1'b0; m_txd[k] = 8'h00;
    end
  endtask

  task automatic model_step(input int k);
    int src;
    src = m_own[k] == 2 ? 1 : 0;
    m_n[k]++;
    m_err[k] = 1'b0;
    m_en[k] = m_own[k] != 0 && tx_en[k][src];
    m_txd[k] = m_own[k] != 0 ? txd[k][src] : 8'h00;
    if (m_own[k] != 0) begin
      if (done[k][src]) begin
        m_own[k] = 0;
        m_free[k] = m_n[k] + IFG + 1;
      end else if (WD && m_n[k] - m_g[k] == MAX) begin
        m_own[k] = 0;
        m_free[k] = m_n[k] + IFG + 1;
        m_err[k] = 1'b1;
      end
    end else if (m_n[k] >= m_free[k] && (req[k][0] || req[k][1])) begin
      m_own[k] = !req[k][1] ? 1 : !req[k][0] ? 2 : (k == 0 || m_last[k] == 2) ? 1 : 2;
      m_last[k] = m_own[k];
      m_g[k] = m_n[k];
    end
    m_busy[k] = m_own[k] != 0 || m_n[k] < m_free[k] - 1;
  endtask

  task automatic check_k(input int k, input string tag);
    logic [12:0] act, exp;
    act = {arp_gnt[k], udp_gnt[k], busy[k], arb_err[k], gmii_tx_en[k], gmii_txd[k]};
    exp = {m_own[k] == 1, m_own[k] == 2, m_busy[k], m_err[k], m_en[k], m_txd[k]};
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d t=%0t observed gnt_a,gnt_u,busy,err,en,txd=%h expected %h", tag, k, $time, act, exp);
    end
  endtask

  task automatic monitor();
    while (!stop) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check_k(k, "cycle");
        model_step(k);
      end
    end
  endtask

  task automatic src_drv(input int k, input int s, input int nfr, input int gap_max,
                         input int len_fix, input bit no_done);
    step();
    for (int f = 0; f < nfr; f++) begin
      int len, w;
      bit early;
      len = len_fix != 0 ? len_fix : $urandom_range(1, 60);
      early = no_done || $urandom_range(0, 1) == 1;
      repeat ($urandom_range(0, gap_max)) begin noise(k, s); step(); end
      req[k][s] = 1'b1;
      w = 0;
      while (!gnt_of(k, s) && w < 2000) begin noise(k, s); step(); w++; end
      n_chk++;
      assert (gnt_of(k, s) === 1'b1) else begin
        n_fail++;
        $error("FAIL grant_wait k=%0d s=%0d observed %b expected 1", k, s, gnt_of(k, s));
      end
      for (int b = 0; b < len; b++) begin
        tx_en[k][s] = (b == 0 || b == len - 1) ? 1'b1 : $urandom_range(0, 7) != 0;
        txd[k][s] = 8'($urandom);
        done[k][s] = b == len - 1 && !no_done;
        if (early || b == len - 1) req[k][s] = 1'b0;
        step();
      end
      quiet(k, s);
    end
  endtask

  task automatic phase(input int na, input int nu, input int gap_max, input int alen,
                       input int ulen, input bit u_nd);
    stop = 1'b0;
    fork
      begin
        fork
          src_drv(0, 0, na, gap_max, alen, 1'b0);
          src_drv(0, 1, nu, gap_max, ulen, u_nd);
          src_drv(1, 0, na, gap_max, alen, 1'b0);
          src_drv(1, 1, nu, gap_max, ulen, u_nd);
        join
        stop = 1'b1;
      end
      monitor();
    join
  endtask

  initial begin
    int w;
    logic [10:0] snap;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 2; s++) begin req[k][s] = 1'b0; quiet(k, s); end
    model_reset();
    #12;
    check_k(0, "reset");
    check_k(1, "reset");
    step();
    rst = 1'b0;
    phase(1, 0, 0, 42, 0, 1'b0);
    phase(1, 1, 0, 0, 0, 1'b0);
    phase(2, 2, 0, 0, 0, 1'b0);
    phase(2, 1, 5, 0, 150, WD);
    phase(10, 10, 20, 0, 0, 1'b0);
    step();
    req[0][1] = 1'b1;
    w = 0;
    while (!udp_gnt[0] && w < 100) begin step(); w++; end
    for (int b = 0; b < 20; b++) begin
      tx_en[0][1] = 1'b1;
      txd[0][1] = 8'(b + 1);
      if (b == 0) req[0][1] = 1'b0;
      step();
    end
    txd[0][1] = 8'd21;
    #2;
    snap = {udp_gnt[0], busy[0], gmii_tx_en[0], gmii_txd[0]};
    n_chk++;
    assert (snap === {3'b111, 8'd20}) else begin
      n_fail++;
      $error("FAIL midframe observed %h expected %h", snap, {3'b111, 8'd20});
    end
    rst = 1'b1;
    #1;
    snap = {udp_gnt[0], busy[0], gmii_tx_en[0], gmii_txd[0]};
    n_chk++;
    assert (snap === 11'h000) else begin
      n_fail++;
      $error("FAIL async_reset observed %h expected 000", snap);
    end
    quiet(0, 1);
    step();
    rst = 1'b0;
    step();
    step();
    snap = {8'h00, arp_gnt[0], udp_gnt[0], busy[0]};
    n_chk++;
    assert (snap === 11'h000) else begin
      n_fail++;
      $error("FAIL idle_after_reset observed %h expected 000", snap);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
